// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage multiply/divide unit.
//   MD_WIDTH      default operand width (HI and LO are each this wide)
//   md_op_e       operation encodings: MULT, MULTU, DIV, DIVU
//   md_state_e    sequencer states: IDLE, CALC, FIX
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit writing the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock,
// followed by one cycle of sign fixup. Start-to-done latency is WIDTH+1 cycles.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, op      launch MULT/MULTU/DIV/DIVU (sampled only in IDLE)
//   A, B           operands; A is also the MTHI/MTLO write data
//   mthi, mtlo     write A into HI/LO (only in IDLE, and only without start)
//   busy, done     busy while computing; done pulses when HI/LO get the result
//   div_by_zero    set with done for a divide by zero, cleared on the next start
//   hi, lo         HI and LO registers
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned W2    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Conditional two's-complement negation; used both for magnitudes and fixup.
    function automatic logic [WIDTH-1:0] twos(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    md_state_e        state;
    md_op_e           op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;  // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;  // multiplier bits / dividend bits becoming quotient
    logic [WIDTH-1:0] b_mag;
    logic             neg_a;
    logic             neg_b;
    logic             b_zero;

    logic             start_signed;
    logic             is_div;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [W2-1:0]    product;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign start_signed = (op == MD_MULT) || (op == MD_DIV);
    assign is_div       = (op_q == MD_DIV) || (op_q == MD_DIVU);

    always_comb begin
        add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_mag};
        // When the subtract succeeds the result is below b_mag, so WIDTH bits suffice.
        div_diff  = div_shift[WIDTH-1:0] - b_mag;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        product = {acc_hi, acc_lo};
        if ((op_q == MD_MULT) && (neg_a ^ neg_b)) begin
            product = ~product + W2'(1);
        end
        fix_hi = product[W2-1:WIDTH];
        fix_lo = product[WIDTH-1:0];
        if (is_div) begin
            // With B==0 every subtract succeeds: the remainder ends as |A|, so
            // re-applying A's sign restores the raw dividend for HI.
            fix_hi = twos(acc_hi, neg_a);
            fix_lo = b_zero ? '1 : twos(acc_lo, neg_a ^ neg_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MD_IDLE;
            op_q        <= MD_MULT;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            b_mag       <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            b_zero      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q        <= md_op_e'(op);
                        neg_a       <= start_signed & A[WIDTH-1];
                        neg_b       <= start_signed & B[WIDTH-1];
                        acc_hi      <= '0;
                        acc_lo      <= twos(A, start_signed & A[WIDTH-1]);
                        b_mag       <= twos(B, start_signed & B[WIDTH-1]);
                        b_zero      <= (B == '0);
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= MD_CALC;
                    end else begin
                        if (mthi) hi <= A;
                        if (mtlo) lo <= A;
                    end
                end
                MD_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) state <= MD_FIX;
                end
                MD_FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    div_by_zero <= is_div & b_zero;
                    state       <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int passed = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the architectural definitions.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic edz);
        logic [63:0] p;
        longint sa, sb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        edz = 1'b0;
        p   = '0;
        case (o)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 0) begin
                    p   = {a, 32'hFFFF_FFFF};
                    edz = 1'b1;
                end else if (o == 2'd2) begin
                    p = {32'(sa % sb), 32'(sa / sb)};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        eh = p[63:32];
        el = p[31:0];
    endfunction

    // Launch one operation and wait (bounded) for done. Optionally injects a
    // start+mthi pair while busy, at cycle inject_at after acceptance.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at,
                          output logic [31:0] rh, output logic [31:0] rl, output logic rdz,
                          output int cycles, output int busy_cnt, output logic busy_at_done,
                          output logic dz_at_accept, output logic held, output logic timeout);
        logic [31:0] h0, l0;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        h0 = hi; l0 = lo;
        @(posedge clk); #1;
        start = 1'b0;
        dz_at_accept = div_by_zero;
        busy_cnt = busy ? 1 : 0;
        held = 1'b1;
        cycles = 0;
        timeout = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            if (c == inject_at) begin
                start = 1'b1; op = 2'b11; A = 32'h0BAD_0BAD; B = 32'd3; mthi = 1'b1;
            end
            @(posedge clk); #1;
            if (c == inject_at) begin
                start = 1'b0; mthi = 1'b0;
            end
            if (done) begin
                cycles = c; timeout = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
        end
        rh = hi; rl = lo; rdz = div_by_zero; busy_at_done = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                     busy, done, div_by_zero, hi, lo);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed operation with checks on result, flag, latency and busy shape.
    task automatic test_directed(input string name, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] want_hi,
                                 input logic [31:0] want_lo, input logic want_dz);
        logic [31:0] rh, rl;
        logic rdz, bad, dza, held, to;
        int cyc, bc;
        run_op(o, a, b, 0, rh, rl, rdz, cyc, bc, bad, dza, held, to);
        total++;
        if (to || cyc != 33)
            $display("FAIL %s_latency: got %0d cycles (timeout=%b), want 33", name, cyc, to);
        else passed++;
        total++;
        if (rh !== want_hi || rl !== want_lo || rdz !== want_dz)
            $display("FAIL %s_result: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                     name, rh, rl, rdz, want_hi, want_lo, want_dz);
        else passed++;
        total++;
        if (bc != 33 || bad !== 1'b0 || dza !== 1'b0)
            $display("FAIL %s_busy: got busy_cycles=%0d busy_at_done=%b dz_at_accept=%b, want 33/0/0",
                     name, bc, bad, dza);
        else passed++;
        total++;
        if (!held)
            $display("FAIL %s_hold: hi/lo changed during CALC, want held until done", name);
        else passed++;
    endtask

    task automatic test_div_by_zero();
        logic [31:0] rh, rl;
        logic rdz, bad, dza, held, to;
        int cyc, bc;
        test_directed("divu_zero", 2'b11, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        total++;
        if (div_by_zero !== 1'b1 || done !== 1'b0)
            $display("FAIL dz_sticky: got dz=%b done=%b, want dz=1 done=0", div_by_zero, done);
        else passed++;
        run_op(2'b01, 32'd6, 32'd7, 0, rh, rl, rdz, cyc, bc, bad, dza, held, to);
        total++;
        if (dza !== 1'b0 || rdz !== 1'b0 || {rh, rl} !== 64'd42)
            $display("FAIL dz_clear: got dz_at_accept=%b dz=%b hi=%h lo=%h, want 0 0 0 2a",
                     dza, rdz, rh, rl);
        else passed++;
        test_directed("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_ignore_busy();
        logic [31:0] rh, rl;
        logic rdz, bad, dza, held, to;
        int cyc, bc;
        run_op(2'b00, 32'h0001_0003, 32'hFFFF_FFF0, 10, rh, rl, rdz, cyc, bc, bad, dza, held, to);
        total++;
        if (to || cyc != 33 || rh !== 32'hFFFF_FFFF || rl !== 32'hFFEF_FFD0 || !held)
            $display("FAIL busy_ignore: got cyc=%0d hi=%h lo=%h held=%b, want 33 ffffffff ffefffd0 1",
                     cyc, rh, rl, held);
        else passed++;
        // The ignored start must not have been queued.
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF)
            $display("FAIL no_queue: got busy=%b hi=%h, want busy=0 hi=ffffffff", busy, hi);
        else passed++;
    endtask

    task automatic test_mt_writes();
        logic [31:0] h0;
        @(negedge clk);
        A = 32'h0000_CAFE; mtlo = 1'b1;
        h0 = hi;
        @(posedge clk); #1;
        mtlo = 1'b0;
        total++;
        if (lo !== 32'h0000_CAFE || hi !== h0)
            $display("FAIL mtlo: got lo=%h hi=%h, want lo=0000cafe hi=%h", lo, hi, h0);
        else passed++;
        @(negedge clk);
        A = 32'h1357_9BDF; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        total++;
        if (hi !== 32'h1357_9BDF || lo !== 32'h1357_9BDF)
            $display("FAIL mthi_mtlo: got hi=%h lo=%h, want both 13579bdf", hi, lo);
        else passed++;
        // start and mthi together: start wins, HI not written.
        @(negedge clk);
        A = 32'd9; B = 32'd4; op = 2'b11; start = 1'b1; mthi = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        total++;
        if (hi !== 32'h1357_9BDF || busy !== 1'b1)
            $display("FAIL start_wins: got hi=%h busy=%b, want hi=13579bdf busy=1", hi, busy);
        else passed++;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk); #1;
        end
        total++;
        if (done !== 1'b1 || hi !== 32'd1 || lo !== 32'd2)
            $display("FAIL start_wins_result: got done=%b hi=%h lo=%h, want 1 1 2", done, hi, lo);
        else passed++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        A = 32'h1111_1111; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        A = 32'd12345; B = 32'd678; op = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'd0)
            $display("FAIL async_reset: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                     busy, done, div_by_zero, hi, lo);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || done) break;
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0)
            $display("FAIL reset_abort: got busy=%b done=%b hi=%h, want 0 0 0", busy, done, hi);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, eh, el, rh, rl;
        logic [1:0] o;
        logic edz, rdz, bad, dza, held, to;
        int cyc, bc;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = (i % 9 == 4) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i % 4 == 1) a = 32'($urandom_range(0, 1000));
            model(o, a, b, eh, el, edz);
            run_op(o, a, b, 0, rh, rl, rdz, cyc, bc, bad, dza, held, to);
            total++;
            if (to || cyc != 33 || rh !== eh || rl !== el || rdz !== edz)
                $display("FAIL random_%0d op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b cyc=%0d, want hi=%h lo=%h dz=%b cyc=33",
                         i, o, a, b, rh, rl, rdz, cyc, eh, el, edz);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed("mult", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        test_directed("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        test_directed("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        test_directed("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        test_directed("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        test_directed("div_mixed", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        test_div_by_zero();
        test_ignore_busy();
        test_mt_writes();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
